// File: rtl/bcd_sevenseg_scanner.sv
// bcd_sevenseg_scanner: buffers a 4-digit BCD word and scans it onto a common-anode 7-seg display, tear-free.
// Latency: an/seg registered (1 clk); an accepted word reaches the display 2..4*SCAN_DIV+1 clks later.
// Backpressure: bcd_ready low while a word waits for the next frame boundary; optional LEADING_ZERO_BLANK_EN.
module bcd_sevenseg_scanner #(
    parameter int SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bcd_in,
    input  logic        bcd_valid,
    output logic        bcd_ready,
    output logic [3:0]  an,
    output logic [6:0]  seg
);
    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [15:0]   pending;
    logic          pending_full;
    logic [15:0]   display;

    logic          tick;
    logic          frame_end;
    logic [3:0]    nib;
    logic [6:0]    seg_nxt;
    logic [3:0]    an_nxt;

    assign tick      = (presc == PRESC_MAX);
    assign frame_end = tick && (idx == 2'd3);
    assign bcd_ready = !pending_full;

    always_comb begin
        nib = display[3:0];
        case (idx)
            2'd0: nib = display[3:0];
            2'd1: nib = display[7:4];
            2'd2: nib = display[11:8];
            2'd3: nib = display[15:12];
            default: nib = display[3:0];
        endcase
        seg_nxt = 7'b0111111;
        case (nib)
            4'd0: seg_nxt = 7'b1000000;
            4'd1: seg_nxt = 7'b1111001;
            4'd2: seg_nxt = 7'b0100100;
            4'd3: seg_nxt = 7'b0110000;
            4'd4: seg_nxt = 7'b0011001;
            4'd5: seg_nxt = 7'b0010010;
            4'd6: seg_nxt = 7'b0000010;
            4'd7: seg_nxt = 7'b1111000;
            4'd8: seg_nxt = 7'b0000000;
            4'd9: seg_nxt = 7'b0010000;
            default: seg_nxt = 7'b0111111;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        // A digit is dark only if it and every more significant digit are zero; units always shows.
        case (idx)
            2'd1: if (display[15:4] == 12'd0) seg_nxt = 7'b1111111;
            2'd2: if (display[15:8] == 8'd0) seg_nxt = 7'b1111111;
            2'd3: if (display[15:12] == 4'd0) seg_nxt = 7'b1111111;
            default: ;
        endcase
`endif
        an_nxt = ~(4'b0001 << idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc        <= '0;
            idx          <= 2'd0;
            pending      <= 16'h0000;
            pending_full <= 1'b0;
            display      <= 16'h0000;
            an           <= 4'b1111;
            seg          <= 7'b1111111;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
                idx <= idx + 2'd1;
            end
            // Commit and accept are exclusive: commit needs a full buffer, accept an empty one.
            if (frame_end && pending_full) begin
                display      <= pending;
                pending_full <= 1'b0;
            end else if (bcd_valid && !pending_full) begin
                pending      <= bcd_in;
                pending_full <= 1'b1;
            end
            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end
endmodule

// File: tb/tb_bcd_sevenseg_scanner.sv
// Scoreboard bench for bcd_sevenseg_scanner at SCAN_DIV=4: accepted words queue up with their
// expected commit edge and are popped when the display frame that must show them begins.
module tb_bcd_sevenseg_scanner;
    localparam int DIV = 4;
    localparam int FRAME = 4 * DIV;

    logic        clk;
    logic        rst_n;
    logic [15:0] bcd_in;
    logic        bcd_valid;
    logic        bcd_ready;
    logic [3:0]  an;
    logic [6:0]  seg;

    bcd_sevenseg_scanner #(.SCAN_DIV(DIV)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bcd_in(bcd_in),
        .bcd_valid(bcd_valid),
        .bcd_ready(bcd_ready),
        .an(an),
        .seg(seg)
    );

    typedef struct {
        logic [15:0] data;
        int          acc;
        int          commit;
    } sb_ent_t;

    sb_ent_t     sb_q[$];
    logic [15:0] cur_exp;
    int          n_checks;
    int          n_fail;
    int          k;

    logic [6:0] seg_tab [16];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [15:0] w, input int slot);
        logic [15:0] hi;
        logic [6:0]  s;
        hi = w >> (4 * slot);
        s  = seg_tab[hi[3:0]];
`ifdef LEADING_ZERO_BLANK_EN
        if (slot > 0 && hi == 16'h0000) s = 7'b1111111;
`endif
        return s;
    endfunction

    // Edges since reset release; edge 1 is the first one that lights a digit.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    logic [3:0] mon_an;
    logic       mon_rdy;
    int         mon_slot;
    sb_ent_t    mon_ent;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_an", 16'(an), 16'h000f);
            check("rst_seg", 16'(seg), 16'h007f);
            check("rst_ready", 16'(bcd_ready), 16'h0001);
        end else if (k >= 1) begin
            mon_slot = ((k - 1) / DIV) % 4;
            if ((k - 1) % FRAME == 0 && sb_q.size() > 0 && sb_q[0].commit == k - 1) begin
                mon_ent = sb_q.pop_front();
                cur_exp = mon_ent.data;
            end
            mon_an = ~(4'b0001 << mon_slot);
            check("an", 16'(an), 16'(mon_an));
            check("seg", 16'(seg), 16'(exp_seg(cur_exp, mon_slot)));
            mon_rdy = 1'b1;
            foreach (sb_q[i]) if (sb_q[i].acc <= k && k < sb_q[i].commit) mon_rdy = 1'b0;
            check("ready", 16'(bcd_ready), 16'(mon_rdy));
        end
    end

    task automatic send(input logic [15:0] w, input bit keep);
        bit      ok;
        sb_ent_t e;
        @(posedge clk);
        #1;
        bcd_in    = w;
        bcd_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (bcd_ready) ok = 1'b1;
        end
        if (!ok) begin
            check("send_timeout", 16'h0000, 16'h0001);
            bcd_valid = 1'b0;
            return;
        end
        e.data   = w;
        e.acc    = k + 1;
        e.commit = ((k + 1) / FRAME + 1) * FRAME;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (!keep) bcd_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
        n_checks  = 0;
        n_fail    = 0;
        cur_exp   = 16'h0000;
        rst_n     = 1'b0;
        bcd_in    = 16'h0000;
        bcd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_cycles(2 * FRAME);

        send(16'h1234, 1'b0);
        wait_cycles(3 * FRAME);

        send(16'h1234, 1'b1);
        send(16'h5678, 1'b0);
        wait_cycles(4 * FRAME);

        send(16'h0A9F, 1'b0);
        wait_cycles(3 * FRAME);
        send(16'h0007, 1'b0);
        wait_cycles(3 * FRAME);
        send(16'h0000, 1'b0);
        wait_cycles(3 * FRAME);
        send(16'h0120, 1'b0);
        wait_cycles(3 * FRAME);

        send(16'h4321, 1'b0);
        begin
            bit found;
            found = 1'b0;
            for (int n = 0; n < 4 * FRAME && !found; n++) begin
                @(negedge clk);
                if ((k / DIV) % 4 == 2 && sb_q.size() > 0 && sb_q[0].acc <= k && k < sb_q[0].commit)
                    found = 1'b1;
            end
            if (!found) check("arst_window", 16'h0000, 16'h0001);
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_an", 16'(an), 16'h000f);
        check("arst_seg", 16'(seg), 16'h007f);
        check("arst_ready", 16'(bcd_ready), 16'h0001);
        sb_q.delete();
        cur_exp = 16'h0000;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_cycles(3 * FRAME);

        check("sb_drained", 16'(sb_q.size()), 16'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
